// File: rtl/gardner_loop_nco.sv
// gardner_loop_nco: Gardner symbol-timing loop closure. A PI loop filter with ACQ/TRACK gains and a lock detector steers a 32 samples/symbol NCO.
// Latency: error_n is sampled in the strobe cycle T; nco_ctrl updates at the end of T+2 (visible T+3); locked is visible from T+2.
// Backpressure: none. error_n is consumed every cycle and all outputs free-run.
// Ports:
//   clk_32M768 - sample clock, rising edge          rst_n    - async active-low reset
//   error_n    - signed timing error, every cycle   loop_en  - 1 closes loop, 0 free-runs NCO
//   sym_strobe - one-cycle pulse per symbol         mu       - fractional interval at strobe
//   nco_ctrl   - signed filter output on NOM_INC    locked   - 1 while the lock FSM is in TRACK
module gardner_loop_nco #(
  parameter int PHASE_W      = 16,
  parameter int NOM_INC      = 2048,
  parameter int MU_W         = 8,
  parameter int KP_SHIFT_ACQ = 4,
  parameter int KI_SHIFT_ACQ = 8,
  parameter int KP_SHIFT     = 6,
  parameter int KI_SHIFT     = 11,
  parameter int INTEG_LIM    = 384,
  parameter int CTRL_LIM     = 512,
  parameter int LOCK_THR     = 1024,
  parameter int LOCK_CNT     = 16,
  parameter int UNLOCK_CNT   = 8
) (
  input  logic                    clk_32M768,
  input  logic                    rst_n,
  input  logic signed [15:0]      error_n,
  input  logic                    loop_en,
  output logic                    sym_strobe,
  output logic [MU_W-1:0]         mu,
  output logic signed [15:0]      nco_ctrl,
  output logic                    locked
);

  // Filter sums are 18 bits wide so 16-bit operands never wrap before saturation.
  localparam int SW = 18;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);

  typedef enum logic {ACQ = 1'b0, TRACK = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [GW-1:0]      good_cnt, good_nxt;
  logic [BW-1:0]      bad_cnt, bad_nxt;

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W:0]   inc, sum;

  logic signed [15:0] e_reg, p_reg, integ;
  logic               v1, v2;          // strobe-sample pipeline occupancy
  logic [4:0]         kp_sh, ki_sh;
  logic signed [SW-1:0] e_ext, integ_sum, ctrl_sum;
  logic [15:0]        e_abs;
  logic               e_good;

  function automatic logic signed [15:0] sat16(input logic signed [SW-1:0] x, input int lim);
    if (x > SW'(lim))
      return 16'(lim);
    else if (x < SW'(-lim))
      return 16'(-lim);
    else
      return 16'(x);
  endfunction

  // NCO: CTRL_LIM < NOM_INC keeps the increment positive, so the sum carry is the symbol wrap.
  assign inc = (PHASE_W+1)'(NOM_INC) + (PHASE_W+1)'(nco_ctrl);
  assign sum = {1'b0, phase} + inc;

  always_ff @(posedge clk_32M768 or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= '0;
      sym_strobe <= 1'b0;
      mu         <= '0;
    end else begin
      phase      <= sum[PHASE_W-1:0];
      sym_strobe <= sum[PHASE_W];
      mu         <= sum[PHASE_W-1 -: MU_W];
    end
  end

  // Gains follow the FSM state at the filter-update cycle.
  always_comb begin
    kp_sh = 5'(KP_SHIFT_ACQ);
    ki_sh = 5'(KI_SHIFT_ACQ);
    if (state == TRACK) begin
      kp_sh = 5'(KP_SHIFT);
      ki_sh = 5'(KI_SHIFT);
    end
  end

  assign e_ext     = SW'(e_reg);
  assign integ_sum = SW'(integ) + (e_ext >>> ki_sh);
  assign ctrl_sum  = SW'(p_reg) + SW'(integ);

  always_ff @(posedge clk_32M768 or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      e_reg    <= '0;
      p_reg    <= '0;
      integ    <= '0;
      nco_ctrl <= '0;
    end else if (!loop_en) begin
      // Open loop: drop anything in flight and park the filter at zero.
      v1       <= 1'b0;
      v2       <= 1'b0;
      p_reg    <= '0;
      integ    <= '0;
      nco_ctrl <= '0;
    end else begin
      v1 <= sym_strobe;
      v2 <= v1;
      if (sym_strobe)
        e_reg <= error_n;
      if (v1) begin
        p_reg <= 16'(e_ext >>> kp_sh);
        integ <= sat16(integ_sum, INTEG_LIM);
      end
      if (v2)
        nco_ctrl <= sat16(ctrl_sum, CTRL_LIM);
    end
  end

  // |e_reg| with the most negative value folded onto +32767.
  always_comb begin
    e_abs = e_reg;
    if (e_reg[15])
      e_abs = (e_reg == 16'sh8000) ? 16'h7fff : 16'(-e_reg);
  end
  assign e_good = (e_abs < 16'(LOCK_THR));

  always_ff @(posedge clk_32M768 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACQ;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      bad_cnt  <= bad_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    bad_nxt   = bad_cnt;
    if (!loop_en) begin
      state_nxt = ACQ;
      good_nxt  = '0;
      bad_nxt   = '0;
    end else if (v1) begin
      case (state)
        ACQ: begin
          if (!e_good) begin
            good_nxt = '0;
          end else if (good_cnt == GW'(LOCK_CNT - 1)) begin
            state_nxt = TRACK;
            good_nxt  = '0;
            bad_nxt   = '0;
          end else begin
            good_nxt = good_cnt + GW'(1);
          end
        end
        TRACK: begin
          if (e_good) begin
            bad_nxt = '0;
          end else if (bad_cnt == BW'(UNLOCK_CNT - 1)) begin
            state_nxt = ACQ;
            good_nxt  = '0;
            bad_nxt   = '0;
          end else begin
            bad_nxt = bad_cnt + BW'(1);
          end
        end
        default: begin
          state_nxt = ACQ;
          good_nxt  = '0;
          bad_nxt   = '0;
        end
      endcase
    end
  end

  assign locked = (state == TRACK);

endmodule

// File: tb/tb_gardner_loop_nco.sv
// tb_gardner_loop_nco: directed scoreboard bench for gardner_loop_nco.
// Stimulus queues one expected record per symbol strobe; a negedge monitor pops and compares.
module tb_gardner_loop_nco;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] error_n;
  logic               loop_en;
  logic               sym_strobe;
  logic [7:0]         mu;
  logic signed [15:0] nco_ctrl;
  logic               locked;

  always #5 clk = ~clk;

  gardner_loop_nco dut (
    .clk_32M768 (clk),
    .rst_n      (rst_n),
    .error_n    (error_n),
    .loop_en    (loop_en),
    .sym_strobe (sym_strobe),
    .mu         (mu),
    .nco_ctrl   (nco_ctrl),
    .locked     (locked)
  );

  typedef struct {
    string nm;
    int    lo;     // interval bounds in cycles; lo==0 skips the interval check
    int    hi;
    int    ctrl;
    int    lk;
    int    mu_v;
    bit    cm;     // compare mu
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic push(input string nm, input int lo, input int hi, input int ctrl,
                      input int lk, input int mu_v, input bit cm);
    exp_t r;
    r.nm = nm; r.lo = lo; r.hi = hi; r.ctrl = ctrl; r.lk = lk; r.mu_v = mu_v; r.cm = cm;
    exp_q.push_back(r);
  endtask

  // Monitor: counts cycles since reset release and checks each strobe against the queue head.
  int   cyc = 0;
  int   last_cyc = 0;
  int   ival;
  exp_t r;
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0;
      last_cyc = 0;
    end else begin
      cyc++;
      if (sym_strobe) begin
        ival = cyc - last_cyc;
        last_cyc = cyc;
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          if (r.lo > 0)
            check_rng({r.nm, ".interval"}, ival, r.lo, r.hi);
          check({r.nm, ".nco_ctrl"}, int'(nco_ctrl), r.ctrl);
          check({r.nm, ".locked"}, locked ? 1 : 0, r.lk);
          if (r.cm)
            check({r.nm, ".mu"}, int'(mu), r.mu_v);
        end
      end
    end
  end

  task automatic wait_drain(input string nm, input int max_cyc);
    bit done = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s drain_timeout pending=%0d required=0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Present e for the next strobe, wait for it, then step just past the capturing edge.
  task automatic drive_strobe(input string nm, input logic signed [15:0] e);
    bit got = 0;
    error_n = e;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sym_strobe) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s strobe_timeout got=0 required=1", nm);
    end
    @(posedge clk);
    #1;
  endtask

  int d_ctrl[18];
  int e_err[8];

  initial begin
    rst_n   = 1'b0;
    loop_en = 1'b0;
    error_n = '0;

    // A: free run, exact 32-cycle symbols from reset release.
    for (int k = 1; k <= 3; k++)
      push($sformatf("A%0d", k), 32, 32, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    check("rst.sym_strobe", int'(sym_strobe), 0);
    check("rst.mu", int'(mu), 0);
    check("rst.nco_ctrl", int'(nco_ctrl), 0);
    check("rst.locked", int'(locked), 0);
    #2 rst_n = 1'b1;
    wait_drain("A", 200);

    // B: constant +4096 in ACQ: 256 proportional + 16 per strobe integral, clamp at 512.
    #1;
    loop_en = 1'b1;
    error_n = 16'sd4096;
    push("B1", 32, 32, 0, 0, 0, 1);
    push("B2", 29, 29, 272, 0, 3, 1);
    for (int j = 3; j <= 16; j++)
      push($sformatf("B%0d", j), 0, 0, 256 + 16 * (j - 1), 0, 0, 0);
    push("B17", 25, 26, 512, 0, 0, 0);
    push("B18", 25, 26, 512, 0, 0, 0);
    wait_drain("B", 1000);

    // C: loop opened briefly (filter to zero), then error 0 -> lock after 16 good strobes.
    #1;
    loop_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    error_n = '0;
    loop_en = 1'b1;
    push("C1", 0, 0, 0, 0, 0, 0);
    for (int j = 2; j <= 18; j++)
      push($sformatf("C%0d", j), 32, 32, 0, (j >= 17) ? 1 : 0, 0, 0);
    wait_drain("C", 1000);

    // D: TRACK gains (>>>6, >>>11) with 20000; 7 bad + 1 good holds lock, then 8 bad drops it.
    #1;
    d_ctrl = '{0, 321, 330, 339, 348, 357, 366, 375, 63,
               384, 393, 402, 411, 420, 429, 438, 447, 512};
    for (int k = 1; k <= 18; k++)
      push($sformatf("D%0d", k), 0, 0, d_ctrl[k-1], (k <= 16) ? 1 : 0, 0, 0);
    for (int k = 1; k <= 18; k++)
      drive_strobe($sformatf("D%0d", k), (k == 8) ? 16'sd0 : 16'sd20000);
    wait_drain("D", 100);

    // E: most negative error saturates integ at -384 and nco_ctrl at -512, then a small
    // positive error shows the integrator was held at the limit rather than wrapped.
    #1;
    loop_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    loop_en = 1'b1;
    e_err = '{-32768, -32768, -32768, -32768, -32768, -32768, 256, 256};
    push("E1", 0, 0, 0, 0, 0, 0);
    push("E2", 0, 0, -512, 0, 0, 0);
    for (int k = 3; k <= 7; k++)
      push($sformatf("E%0d", k), 42, 43, -512, 0, 0, 0);
    push("E8", 0, 0, -367, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      drive_strobe($sformatf("E%0d", k), 16'(e_err[k-1]));
    wait_drain("E", 100);

    // F: asynchronous reset mid-symbol with a live control word, then a clean restart.
    repeat (5) @(posedge clk);
    #3;
    check("F.pre_ctrl", int'(nco_ctrl), -366);
    rst_n = 1'b0;
    #1;
    check("F.sym_strobe", int'(sym_strobe), 0);
    check("F.mu", int'(mu), 0);
    check("F.nco_ctrl", int'(nco_ctrl), 0);
    check("F.locked", int'(locked), 0);
    error_n = '0;
    push("F1", 32, 32, 0, 0, 0, 1);
    push("F2", 32, 32, 0, 0, 0, 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_drain("F", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d errors=%0d required=finish", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
